instr_fetch: RTL and testbench

Byte-serial instruction fetch stage sitting directly downstream of the program counter. Each clock it samples the program-ROM byte addressed by the current PCHI:PCLO and shifts it into an assembly register. After INSTR_BYTES consecutive bytes it presents a complete instruction, with its start address, to the decoder. A PC load (jump) flushes any partially assembled instruction so that assembly restarts at the new address.

---
 rtl/spam1_fetch_pkg.sv | 14 +
 rtl/instr_fetch.sv | 84 ++++++++
 tb/tb_instr_fetch.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spam1_fetch_pkg.sv
// Shared definitions for the byte-serial instruction fetch stage.
//   INSTR_BYTES_DEFAULT : default number of bytes per instruction
//   PHASE_W             : width of the byte-phase counter for the default size
//   instr_t             : one assembled instruction at the default size
//   addr_t              : a 16-bit program address (PCHI:PCLO)
package spam1_fetch_pkg;

  localparam int INSTR_BYTES_DEFAULT = 4;
  localparam int PHASE_W             = $clog2(INSTR_BYTES_DEFAULT);

  typedef logic [8*INSTR_BYTES_DEFAULT-1:0] instr_t;
  typedef logic [15:0]                      addr_t;

endpackage

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch stage. Each rising edge captures the ROM byte
// at the current PC into a shift buffer. After INSTR_BYTES bytes it publishes
// the whole instruction together with the address of its first byte. A PC
// load (jump) discards the partial instruction and restarts assembly.
//
// Ports:
//   clk         in   system clock, rising edge
//   _MR         in   synchronous active-low reset, priority over _jump
//   PCHI, PCLO  in   current PC high/low bytes
//   rom_data    in   ROM byte at PCHI:PCLO, stable before the edge
//   _jump       in   active-low, PC loads instead of incrementing this edge
//   instr       out  last completed instruction, first byte in the MSBs
//   instr_addr  out  address of the first byte of instr
//   instr_valid out  high once any instruction has completed since reset
//   instr_new   out  one-cycle strobe after an instruction completes
//   phase       out  index of the next byte to be captured
module instr_fetch
  import spam1_fetch_pkg::*;
#(
  parameter int INSTR_BYTES = INSTR_BYTES_DEFAULT,
  parameter int ADDR_W      = 16
) (
  input  logic                                clk,
  input  logic                                _MR,
  input  logic [7:0]                          PCHI,
  input  logic [7:0]                          PCLO,
  input  logic [7:0]                          rom_data,
  input  logic                                _jump,
  output logic [8*INSTR_BYTES-1:0]            instr,
  output logic [ADDR_W-1:0]                   instr_addr,
  output logic                                instr_valid,
  output logic                                instr_new,
  output logic [$clog2(INSTR_BYTES)-1:0]      phase
);

  localparam int PW = $clog2(INSTR_BYTES);
  // The top byte of a full shift would be shifted out before it is ever used,
  // so the buffer only keeps the INSTR_BYTES-1 most recent bytes.
  localparam int BW = 8 * (INSTR_BYTES - 1);
  localparam logic [PW-1:0] LAST_PHASE = PW'(INSTR_BYTES - 1);

  logic [BW-1:0]     buffer;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] pc_addr;

  assign pc_addr = ADDR_W'({PCHI, PCLO});

  // NOTE: sequential state is assigned with <= only, so every register here
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!_MR) begin
      // NOTE: the assembly buffer is a plain register (not a RAM), so clearing
      // it on reset costs nothing and keeps the outputs deterministic.
      buffer      <= '0;
      start_addr  <= '0;
      phase       <= '0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      instr_new   <= 1'b0;
    end else if (!_jump) begin
      // The byte on rom_data belongs to the abandoned stream; drop it and keep
      // the last completed instruction visible to the decoder.
      phase     <= '0;
      instr_new <= 1'b0;
    end else begin
      buffer <= BW'({buffer, rom_data});
      if (phase == '0) begin
        start_addr <= pc_addr;
      end
      if (phase == LAST_PHASE) begin
        instr       <= {buffer, rom_data};
        instr_addr  <= start_addr;
        instr_valid <= 1'b1;
        instr_new   <= 1'b1;
        phase       <= '0;
      end else begin
        phase     <= phase + 1'b1;
        instr_new <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// jumps/resets, compared every edge against a queue-based reference model.
module tb_instr_fetch;

  localparam int NB = 4;

  logic            clk = 1'b0;
  logic            mr_n = 1'b0;
  logic            jump_n = 1'b1;
  logic [15:0]     pc = 16'h0000;
  logic [7:0]      rom [0:65535];
  logic [7:0]      rom_data;
  logic [8*NB-1:0] instr;
  logic [15:0]     instr_addr;
  logic            instr_valid;
  logic            instr_new;
  logic [1:0]      phase;

  int checks = 0;
  int errors = 0;

  // Reference model state: bytes captured since the last flush.
  logic [7:0]      q[$];
  logic [15:0]     q_addr0;
  logic [8*NB-1:0] exp_instr;
  logic [15:0]     exp_addr;
  logic            exp_valid;
  logic            exp_new;

  always #5 clk = ~clk;

  assign rom_data = rom[pc];

  instr_fetch #(.INSTR_BYTES(NB), .ADDR_W(16)) dut (
    .clk         (clk),
    ._MR         (mr_n),
    .PCHI        (pc[15:8]),
    .PCLO        (pc[7:0]),
    .rom_data    (rom_data),
    ._jump       (jump_n),
    .instr       (instr),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_new   (instr_new),
    .phase       (phase)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check("instr", 64'(instr), 64'(exp_instr));
    check("instr_addr", 64'(instr_addr), 64'(exp_addr));
    check("instr_valid", 64'(instr_valid), 64'(exp_valid));
    check("instr_new", 64'(instr_new), 64'(exp_new));
    check("phase", 64'(phase), 64'(q.size()));
  endtask

  // One clock edge with the given control inputs. The PC model increments on
  // normal edges, loads target on jump edges, and clears on reset.
  task automatic step(input logic mr, input logic jmp, input logic [15:0] target);
    logic [15:0] cur_pc;
    logic [7:0]  cur_byte;
    mr_n     = mr;
    jump_n   = jmp;
    cur_pc   = pc;
    cur_byte = rom[pc];
    @(posedge clk);
    #1;
    if (!mr) begin
      q.delete();
      exp_instr = '0;
      exp_addr  = '0;
      exp_valid = 1'b0;
      exp_new   = 1'b0;
      pc        = 16'h0000;
    end else if (!jmp) begin
      q.delete();
      exp_new = 1'b0;
      pc      = target;
    end else begin
      if (q.size() == 0) q_addr0 = cur_pc;
      q.push_back(cur_byte);
      exp_new = 1'b0;
      if (q.size() == NB) begin
        exp_instr = '0;
        foreach (q[i]) exp_instr = {exp_instr[8*NB-9:0], q[i]};
        exp_addr  = q_addr0;
        exp_valid = 1'b1;
        exp_new   = 1'b1;
        q.delete();
      end
      pc = cur_pc + 16'd1;
    end
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 16'h0000);
  endtask

  initial begin
    exp_instr = '0;
    exp_addr  = '0;
    exp_valid = 1'b0;
    exp_new   = 1'b0;
    q_addr0   = '0;
    for (int a = 0; a < 65536; a++) rom[a] = 8'($urandom);
    rom[0] = 8'h12; rom[1] = 8'h34; rom[2] = 8'h56; rom[3] = 8'h78;
    rom[16'h2000] = 8'hAA; rom[16'h2001] = 8'hBB;
    rom[16'h2002] = 8'hCC; rom[16'h2003] = 8'hDD;

    // Reset, then the first instruction from 0000.
    step(1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 16'h0000);
    check("reset_instr", 64'(instr), 64'h0);
    run(4);
    check("first_instr", 64'(instr), 64'h12345678);
    check("first_addr", 64'(instr_addr), 64'h0000);
    check("first_new", 64'(instr_new), 64'h1);

    // Free run across two more instructions.
    run(8);
    check("run_addr", 64'(instr_addr), 64'h0008);

    // Jump at phase 2 to 2000.
    run(2);
    check("pre_jump_phase", 64'(phase), 64'h2);
    step(1'b1, 1'b0, 16'h2000);
    check("jump_new", 64'(instr_new), 64'h0);
    check("jump_phase", 64'(phase), 64'h0);
    run(4);
    check("jump_instr", 64'(instr), 64'hAABBCCDD);
    check("jump_addr", 64'(instr_addr), 64'h2000);

    // Jump on the completing edge: previous instruction retained.
    run(3);
    step(1'b1, 1'b0, 16'hFFFE);
    check("jlast_instr", 64'(instr), 64'hAABBCCDD);
    check("jlast_addr", 64'(instr_addr), 64'h2000);
    check("jlast_new", 64'(instr_new), 64'h0);

    // Wrap through FFFF -> 0000.
    rom[16'hFFFE] = 8'h01; rom[16'hFFFF] = 8'h02;
    rom[16'h0000] = 8'h03; rom[16'h0001] = 8'h04;
    run(4);
    check("wrap_instr", 64'(instr), 64'h01020304);
    check("wrap_addr", 64'(instr_addr), 64'hFFFE);

    // Reset mid-assembly together with a jump.
    run(2);
    step(1'b0, 1'b0, 16'h1234);
    check("mr_instr", 64'(instr), 64'h0);
    check("mr_valid", 64'(instr_valid), 64'h0);
    run(4);
    check("mr_after_addr", 64'(instr_addr), 64'h0000);

    // Random jumps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r == 0)      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
      else if (r < 15) step(1'b1, 1'b0, 16'($urandom));
      else             step(1'b1, 1'b1, 16'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
